// File: rtl/vpu_src_port_arbiter_if.sv
// Purpose : bundles the requester-channel and SRAM read-port signals of the
//           VPU source-port arbiter into one interface.
// Ports   : ch_*   - NUM_CH packed requester channels (req/ack, rid/addr/reb/
//                    rlast, shared rdata with one-hot rvalid)
//           sram_* - single SRAM read port
//           outst_cnt / err_unexp - arbiter status
// Modports: slave  - arbiter view
//           master - environment view (requesters plus SRAM)
interface vpu_src_port_arbiter_if #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned RID_W     = 5,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 4
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH*RID_W-1:0]  ch_rid;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_reb;
  logic [NUM_CH-1:0]        ch_rlast;
  logic [DATA_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_rvalid;

  logic                     sram_req;
  logic                     sram_ack;
  logic [RID_W-1:0]         sram_rid;
  logic [ADDR_W-1:0]        sram_addr;
  logic                     sram_reb;
  logic                     sram_rlast;
  logic [DATA_W-1:0]        sram_rdata;
  logic                     sram_rvalid;

  logic [CNT_W-1:0]         outst_cnt;
  logic                     err_unexp;

  modport slave (
    input  ch_req, ch_rid, ch_addr, ch_reb, ch_rlast,
    output ch_ack, ch_rdata, ch_rvalid,
    output sram_req, sram_rid, sram_addr, sram_reb, sram_rlast,
    input  sram_ack, sram_rdata, sram_rvalid,
    output outst_cnt, err_unexp
  );

  modport master (
    output ch_req, ch_rid, ch_addr, ch_reb, ch_rlast,
    input  ch_ack, ch_rdata, ch_rvalid,
    input  sram_req, sram_rid, sram_addr, sram_reb, sram_rlast,
    output sram_ack, sram_rdata, sram_rvalid,
    input  outst_cnt, err_unexp
  );
endinterface

// File: rtl/vpu_src_port_arbiter.sv
// Purpose : merges NUM_CH source-operand read channels onto one SRAM read
//           port. Round-robin grant with burst lock; an in-order routing FIFO
//           steers every returned beat back to the channel that issued it.
// Ports   : clk   - clock
//           rst_n - synchronous active-low reset
//           bus   - vpu_src_port_arbiter_if.slave (channel side, SRAM side,
//                   outst_cnt, err_unexp)
// Notes   : sram_req/rid/addr/reb/rlast and ch_ack are combinational from the
//           owner's inputs; ch_rdata/ch_rvalid are registered (latency 1).
//           MAX_OUTST must be a power of two, at least 2.
module vpu_src_port_arbiter #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned RID_W     = 5,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vpu_src_port_arbiter_if.slave    bus
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_owner, r_rr_ptr;
  logic [CH_W-1:0]     w_pick, w_cand;
  logic                w_any_req;
  logic                w_full, w_sram_req, w_accept, w_pop;
  logic [NUM_CH-1:0]   w_ch_ack;
  logic [RID_W-1:0]    w_rid;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_reb, w_rlast;

  logic [RID_W-1:0]    w_rid_arr  [NUM_CH];
  logic [ADDR_W-1:0]   w_addr_arr [NUM_CH];

  logic [CH_W-1:0]     r_fifo [MAX_OUTST];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [NUM_CH-1:0]   r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  // Unpack the flat per-channel buses so the owner can select them directly
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_rid_arr[g]  = bus.ch_rid[g*RID_W +: RID_W];
    assign w_addr_arr[g] = bus.ch_addr[g*ADDR_W +: ADDR_W];
  end

  // Full uses the registered count only, so a same-cycle pop cannot unblock
  assign w_full = (r_cnt == CNT_W'(MAX_OUTST));
  assign w_pop  = bus.sram_rvalid && (r_cnt != '0);

  // Round-robin pick: first requester at or after r_rr_ptr, cyclically
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = '0;
    w_cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_cand = CH_W'((32'(r_rr_ptr) + i) % NUM_CH);
      if (!w_any_req && bus.ch_req[w_cand]) begin
        w_any_req = 1'b1;
        w_pick    = w_cand;
      end
    end
  end

  // Next-state and SRAM-side outputs
  always_comb begin
    w_state_nxt = r_state;
    w_sram_req  = 1'b0;
    w_accept    = 1'b0;
    w_ch_ack    = '0;
    w_rid       = '0;
    w_addr      = '0;
    w_reb       = 1'b1;
    w_rlast     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_LOCK;
      end
      ST_LOCK: begin
        w_rid      = w_rid_arr[r_owner];
        w_addr     = w_addr_arr[r_owner];
        w_reb      = bus.ch_reb[r_owner];
        w_rlast    = bus.ch_rlast[r_owner];
        w_sram_req = bus.ch_req[r_owner] && !w_full;
        w_accept   = w_sram_req && bus.sram_ack;
        if (w_accept) begin
          w_ch_ack = NUM_CH'(1) << r_owner;
          // Burst lock releases only on the owner's last beat
          if (w_rlast) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Owner capture and round-robin pointer advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) r_owner <= w_pick;
      if (w_accept && w_rlast)
        r_rr_ptr <= (r_owner == CH_W'(NUM_CH - 1)) ? '0 : r_owner + CH_W'(1);
    end
  end

  // Routing FIFO storage; emptiness is tracked by r_cnt, so no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) r_fifo[r_wr_ptr] <= r_owner;
  end

  // FIFO pointers, outstanding count, return path and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (bus.sram_rvalid && r_cnt == '0) r_err <= 1'b1;
      r_rvalid <= w_pop ? (NUM_CH'(1) << r_fifo[r_rd_ptr]) : '0;
      if (w_pop) r_rdata <= bus.sram_rdata;
    end
  end

  assign bus.sram_req   = w_sram_req;
  assign bus.sram_rid   = w_rid;
  assign bus.sram_addr  = w_addr;
  assign bus.sram_reb   = w_reb;
  assign bus.sram_rlast = w_rlast;
  assign bus.ch_ack     = w_ch_ack;
  assign bus.ch_rvalid  = r_rvalid;
  assign bus.ch_rdata   = r_rdata;
  assign bus.outst_cnt  = r_cnt;
  assign bus.err_unexp  = r_err;
endmodule

// File: tb/tb_vpu_src_port_arbiter.sv
// Purpose : self-checking bench for vpu_src_port_arbiter. Directed stimulus
//           pushes expected grants and returns into queues; two monitors pop
//           and compare whenever the DUT accepts a beat or presents ch_rvalid.
module tb_vpu_src_port_arbiter;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned RID_W     = 5;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned MAX_OUTST = 4;

  typedef struct {
    int               ch;
    logic [RID_W-1:0] rid;
    logic [ADDR_W-1:0] addr;
    logic             rlast;
  } grant_t;

  typedef struct {
    logic [NUM_CH-1:0] oh;
    logic [DATA_W-1:0] data;
    int                cyc;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  grant_t gq[$];
  ret_t   rq[$];
  grant_t mon_g;
  ret_t   mon_r;

  vpu_src_port_arbiter_if #(
    .NUM_CH(NUM_CH), .RID_W(RID_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) bus ();

  vpu_src_port_arbiter #(
    .NUM_CH(NUM_CH), .RID_W(RID_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] dpat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic set_ch(input int c, input logic req, input logic [RID_W-1:0] rid,
                        input logic [ADDR_W-1:0] addr, input logic rlast);
    bus.ch_req[c]                  = req;
    bus.ch_reb[c]                  = ~req;
    bus.ch_rid[c*RID_W +: RID_W]   = rid;
    bus.ch_addr[c*ADDR_W +: ADDR_W] = addr;
    bus.ch_rlast[c]                = rlast;
  endtask

  task automatic exp_grant(input int c, input logic [RID_W-1:0] rid,
                           input logic [ADDR_W-1:0] addr, input logic rlast);
    grant_t g;
    g.ch = c; g.rid = rid; g.addr = addr; g.rlast = rlast;
    gq.push_back(g);
  endtask

  // Drives one return beat now; routed data must appear exactly one cycle later
  task automatic drive_ret(input logic [NUM_CH-1:0] oh, input logic [DATA_W-1:0] d);
    ret_t r;
    bus.sram_rvalid = 1'b1;
    bus.sram_rdata  = d;
    r.oh = oh; r.data = d; r.cyc = cyc + 1;
    rq.push_back(r);
  endtask

  task automatic ret(input logic [NUM_CH-1:0] oh, input logic [DATA_W-1:0] d);
    drive_ret(oh, d);
    tick;
    bus.sram_rvalid = 1'b0;
  endtask

  task automatic do_reset;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  // Accept monitor: every ack must match the next expected grant
  always @(negedge clk) begin
    if (rst_n && ((bus.sram_req && bus.sram_ack) || bus.ch_ack != '0)) begin
      n_checks++;
      if (gq.size() == 0) begin
        n_errors++;
        $display("FAIL accept_unexp: ch_ack=%b sram_req=%b rid=%0h addr=%0h",
                 bus.ch_ack, bus.sram_req, bus.sram_rid, bus.sram_addr);
      end else begin
        mon_g = gq.pop_front();
        if (!(bus.sram_req && bus.sram_ack) || bus.ch_ack !== (3'b001 << mon_g.ch) ||
            bus.sram_rid !== mon_g.rid || bus.sram_addr !== mon_g.addr ||
            bus.sram_rlast !== mon_g.rlast || bus.sram_reb !== 1'b0) begin
          n_errors++;
          $display("FAIL accept: got ack=%b req=%b rid=%0h addr=%0h rlast=%b reb=%b expected ch=%0d rid=%0h addr=%0h rlast=%b",
                   bus.ch_ack, bus.sram_req, bus.sram_rid, bus.sram_addr, bus.sram_rlast,
                   bus.sram_reb, mon_g.ch, mon_g.rid, mon_g.addr, mon_g.rlast);
        end
      end
    end
  end

  // Return monitor: routed beats must match channel, data and latency
  always @(negedge clk) begin
    if (rst_n && bus.ch_rvalid != '0) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_errors++;
        $display("FAIL return_unexp: ch_rvalid=%b data=%0h", bus.ch_rvalid, bus.ch_rdata[63:0]);
      end else begin
        mon_r = rq.pop_front();
        if (bus.ch_rvalid !== mon_r.oh || bus.ch_rdata !== mon_r.data || cyc != mon_r.cyc) begin
          n_errors++;
          $display("FAIL return: got rvalid=%b data=%0h cyc=%0d expected rvalid=%b data=%0h cyc=%0d",
                   bus.ch_rvalid, bus.ch_rdata[63:0], cyc, mon_r.oh, mon_r.data[63:0], mon_r.cyc);
        end
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.ch_req      = '0;
    bus.ch_reb      = '1;
    bus.ch_rid      = '0;
    bus.ch_addr     = '0;
    bus.ch_rlast    = '0;
    bus.sram_ack    = 1'b0;
    bus.sram_rdata  = '0;
    bus.sram_rvalid = 1'b0;

    // Reset values
    repeat (3) tick;
    neg;
    chk("rst_ch_ack",    64'(bus.ch_ack), 64'(0));
    chk("rst_ch_rvalid", 64'(bus.ch_rvalid), 64'(0));
    chk("rst_ch_rdata",  64'(|bus.ch_rdata), 64'(0));
    chk("rst_sram_req",  64'(bus.sram_req), 64'(0));
    chk("rst_sram_reb",  64'(bus.sram_reb), 64'(1));
    chk("rst_sram_rlast",64'(bus.sram_rlast), 64'(0));
    chk("rst_sram_rid",  64'(bus.sram_rid), 64'(0));
    chk("rst_sram_addr", 64'(bus.sram_addr), 64'(0));
    chk("rst_outst",     64'(bus.outst_cnt), 64'(0));
    chk("rst_err",       64'(bus.err_unexp), 64'(0));
    tick;
    rst_n = 1'b1;

    // Single beat on ch0
    set_ch(0, 1'b1, 5'd5, 10'h012, 1'b1);
    bus.sram_ack = 1'b1;
    exp_grant(0, 5'd5, 10'h012, 1'b1);
    neg;
    chk("t1_idle_req", 64'(bus.sram_req), 64'(0));
    neg;
    chk("t1_lock_req", 64'(bus.sram_req), 64'(1));
    chk("t1_ack",      64'(bus.ch_ack), 64'(3'b001));
    tick;
    set_ch(0, 1'b0, 5'd5, 10'h012, 1'b1);
    neg;
    chk("t1_outst1",   64'(bus.outst_cnt), 64'(1));
    chk("t1_req_idle", 64'(bus.sram_req), 64'(0));
    tick;
    ret(3'b001, dpat(8'hA5));
    neg;
    chk("t1_outst0",   64'(bus.outst_cnt), 64'(0));
    tick;
    neg;
    chk("t1_rvalid_off", 64'(bus.ch_rvalid), 64'(0));
    chk("t1_rdata_hold", bus.ch_rdata[63:0], 64'hA5A5_A5A5_A5A5_A5A5);

    // Round-robin across three continuous requesters
    do_reset;
    set_ch(0, 1'b1, 5'd1, 10'h021, 1'b1);
    set_ch(1, 1'b1, 5'd2, 10'h022, 1'b1);
    set_ch(2, 1'b1, 5'd3, 10'h023, 1'b1);
    exp_grant(0, 5'd1, 10'h021, 1'b1);
    exp_grant(1, 5'd2, 10'h022, 1'b1);
    exp_grant(2, 5'd3, 10'h023, 1'b1);
    exp_grant(0, 5'd1, 10'h021, 1'b1);
    for (int k = 0; k < 8; k++) begin
      neg;
      chk($sformatf("t2_req_%0d", k), 64'(bus.sram_req), 64'(k % 2));
    end
    tick;
    bus.ch_req = '0;
    bus.ch_reb = '1;
    neg;
    chk("t2_outst4", 64'(bus.outst_cnt), 64'(4));
    tick;
    ret(3'b001, dpat(8'hD1));
    ret(3'b010, dpat(8'hD2));
    ret(3'b100, dpat(8'hD3));
    ret(3'b001, dpat(8'hD4));
    neg;
    chk("t2_outst0", 64'(bus.outst_cnt), 64'(0));

    // Burst lock: ch0 three beats (with a mid-burst req drop) while ch1 waits
    do_reset;
    set_ch(0, 1'b1, 5'd4, 10'h030, 1'b0);
    set_ch(1, 1'b1, 5'd6, 10'h040, 1'b1);
    exp_grant(0, 5'd4, 10'h030, 1'b0);
    neg;
    chk("t3_idle_req", 64'(bus.sram_req), 64'(0));
    neg;
    chk("t3_beat1", 64'(bus.ch_ack), 64'(3'b001));
    tick;
    set_ch(0, 1'b0, 5'd4, 10'h030, 1'b0);
    neg;
    chk("t3_drop_req", 64'(bus.sram_req), 64'(0));
    chk("t3_drop_ack", 64'(bus.ch_ack), 64'(0));
    tick;
    set_ch(0, 1'b1, 5'd4, 10'h031, 1'b0);
    exp_grant(0, 5'd4, 10'h031, 1'b0);
    neg;
    chk("t3_beat2", 64'(bus.ch_ack), 64'(3'b001));
    tick;
    set_ch(0, 1'b1, 5'd4, 10'h032, 1'b1);
    exp_grant(0, 5'd4, 10'h032, 1'b1);
    neg;
    chk("t3_beat3", 64'(bus.ch_ack), 64'(3'b001));
    tick;
    set_ch(0, 1'b0, 5'd4, 10'h032, 1'b1);
    exp_grant(1, 5'd6, 10'h040, 1'b1);
    neg;
    chk("t3_gap_req", 64'(bus.sram_req), 64'(0));
    chk("t3_gap_ack", 64'(bus.ch_ack), 64'(0));
    neg;
    chk("t3_ch1_ack", 64'(bus.ch_ack), 64'(3'b010));
    tick;
    bus.ch_req = '0;
    bus.ch_reb = '1;
    neg;
    chk("t3_outst4", 64'(bus.outst_cnt), 64'(4));
    tick;
    ret(3'b001, dpat(8'h31));
    ret(3'b001, dpat(8'h32));
    ret(3'b001, dpat(8'h33));
    ret(3'b010, dpat(8'h34));

    // Back-pressure at MAX_OUTST with withheld returns
    do_reset;
    set_ch(0, 1'b1, 5'd7, 10'h050, 1'b0);
    neg;
    for (int k = 0; k < 4; k++) begin
      exp_grant(0, 5'd7, 10'(32'h50 + k), 1'b0);
      neg;
      chk($sformatf("t4_acc_%0d", k), 64'(bus.ch_ack), 64'(3'b001));
      tick;
      set_ch(0, 1'b1, 5'd7, 10'(32'h51 + k), 1'b0);
    end
    neg;
    chk("t4_full_req", 64'(bus.sram_req), 64'(0));
    chk("t4_full_cnt", 64'(bus.outst_cnt), 64'(4));
    tick;
    neg;
    chk("t4_full_req2", 64'(bus.sram_req), 64'(0));
    tick;
    drive_ret(3'b001, dpat(8'h41));
    neg;
    chk("t4_pop_noblk", 64'(bus.sram_req), 64'(0));
    chk("t4_pop_cnt",   64'(bus.outst_cnt), 64'(4));
    tick;
    bus.sram_rvalid = 1'b0;
    set_ch(0, 1'b1, 5'd7, 10'h054, 1'b1);
    exp_grant(0, 5'd7, 10'h054, 1'b1);
    neg;
    chk("t4_cnt3",   64'(bus.outst_cnt), 64'(3));
    chk("t4_resume", 64'(bus.sram_req), 64'(1));
    tick;
    bus.ch_req = '0;
    bus.ch_reb = '1;
    neg;
    chk("t4_cnt4b", 64'(bus.outst_cnt), 64'(4));
    tick;
    ret(3'b001, dpat(8'h42));
    ret(3'b001, dpat(8'h43));
    ret(3'b001, dpat(8'h44));
    ret(3'b001, dpat(8'h45));
    neg;
    chk("t4_cnt0", 64'(bus.outst_cnt), 64'(0));

    // Simultaneous accept and pop at outst_cnt=2, mixed channels
    do_reset;
    set_ch(1, 1'b1, 5'd9,  10'h060, 1'b1);
    set_ch(2, 1'b1, 5'd10, 10'h061, 1'b1);
    set_ch(0, 1'b0, 5'd11, 10'h062, 1'b1);
    exp_grant(1, 5'd9,  10'h060, 1'b1);
    exp_grant(2, 5'd10, 10'h061, 1'b1);
    exp_grant(0, 5'd11, 10'h062, 1'b1);
    neg;
    neg;
    neg;
    neg;
    tick;
    set_ch(1, 1'b0, 5'd9,  10'h060, 1'b1);
    set_ch(2, 1'b0, 5'd10, 10'h061, 1'b1);
    set_ch(0, 1'b1, 5'd11, 10'h062, 1'b1);
    neg;
    chk("t5_cnt2a", 64'(bus.outst_cnt), 64'(2));
    tick;
    drive_ret(3'b010, dpat(8'h51));
    neg;
    chk("t5_acc_ack", 64'(bus.ch_ack), 64'(3'b001));
    chk("t5_cnt2b",   64'(bus.outst_cnt), 64'(2));
    tick;
    bus.sram_rvalid = 1'b0;
    bus.ch_req = '0;
    bus.ch_reb = '1;
    neg;
    chk("t5_cnt2c", 64'(bus.outst_cnt), 64'(2));
    tick;
    ret(3'b100, dpat(8'h52));
    ret(3'b001, dpat(8'h53));
    neg;
    chk("t5_cnt0", 64'(bus.outst_cnt), 64'(0));

    // Unexpected return with FIFO empty, then reset clears the sticky error
    tick;
    bus.sram_rvalid = 1'b1;
    bus.sram_rdata  = dpat(8'hEE);
    neg;
    chk("t6_err_pre", 64'(bus.err_unexp), 64'(0));
    tick;
    bus.sram_rvalid = 1'b0;
    neg;
    chk("t6_err_set",    64'(bus.err_unexp), 64'(1));
    chk("t6_no_rvalid",  64'(bus.ch_rvalid), 64'(0));
    tick;
    neg;
    chk("t6_err_sticky", 64'(bus.err_unexp), 64'(1));
    tick;
    rst_n = 1'b0;
    neg;
    chk("t6_err_before_edge", 64'(bus.err_unexp), 64'(1));
    tick;
    rst_n = 1'b1;
    neg;
    chk("t6_err_clr",  64'(bus.err_unexp), 64'(0));
    chk("t6_cnt_clr",  64'(bus.outst_cnt), 64'(0));
    chk("t6_req_clr",  64'(bus.sram_req), 64'(0));

    // Drain: all expected grants and returns must have been consumed
    for (int k = 0; k < 20 && (gq.size() != 0 || rq.size() != 0); k++) tick;
    chk("grant_q_empty",  64'(gq.size()), 64'(0));
    chk("return_q_empty", 64'(rq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vpu_src_port_arbiter.md
Name: vpu_src_port_arbiter

Overview:
- Parametrised successor to the single-requester VPU SRAM source port.
- Merges NUM_CH source-operand read channels (src0..src2 by default) onto one SRAM read port.
- Each channel uses the existing req/ack + rid/addr/reb/rlast + rdata/rvalid protocol.
- Round-robin arbitration with burst lock. An in-order routing FIFO returns each rdata beat to the channel that issued it, with bounded outstanding reads.

Parameters:
NUM_CH, 3, number of requester channels (≥2)
RID_W, 5, SRAM bank-id width (SRAM_BANK_CNT_LG2)
ADDR_W, 10, SRAM bank address width (SRAM_BANK_DEPTH_LG2)
DATA_W, 512, SRAM data width (SRAM_DATA_WIDTH)
MAX_OUTST, 4, routing FIFO depth = max accepted-but-unreturned beats (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ch_req  in  NUM_CH  per-channel read request
ch_ack  out  NUM_CH  per-channel beat accepted
ch_rid  in  NUM_CH*RID_W  per-channel bank id, channel i at [i*RID_W +: RID_W]
ch_addr  in  NUM_CH*ADDR_W  per-channel bank address
ch_reb  in  NUM_CH  per-channel read enable, active-low
ch_rlast  in  NUM_CH  last beat of channel burst
ch_rdata  out  DATA_W  returned data, shared by all channels
ch_rvalid  out  NUM_CH  one-hot: ch_rdata valid for channel i
sram_req  out  1  request to SRAM
sram_ack  in  1  SRAM accepts beat
sram_rid  out  RID_W  bank id
sram_addr  out  ADDR_W  address
sram_reb  out  1  read enable, active-low
sram_rlast  out  1  last beat
sram_rdata  in  DATA_W  read data
sram_rvalid  in  1  read data valid (returns in acceptance order)
outst_cnt  out  $clog2(MAX_OUTST)+1  beats outstanding
err_unexp  out  1  sticky: sram_rvalid seen with FIFO empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values:
  - ch_ack=0, ch_rvalid=0, ch_rdata=0.
  - sram_req=0, sram_reb=1, sram_rlast=0, sram_rid=0, sram_addr=0.
  - outst_cnt=0, err_unexp=0.
  - FSM=IDLE, rr_ptr=0, owner=0, FIFO empty.
- Reset mid-operation: aborts the burst and discards the FIFO. Any later sram_rvalid for pre-reset beats sets err_unexp. Benches must not reset with outst_cnt≠0 unless testing this.
- FSM IDLE:
  - Outputs: sram_req=0, sram_reb=1, ch_ack=0.
  - If any ch_req is high, pick the first requesting channel at or after rr_ptr (cyclic). Register it as owner and go to LOCK.
  - If no ch_req is high, stay in IDLE.
  - Cost: one bubble cycle per burst.
- FSM LOCK:
  - sram_req = ch_req[owner] & (outst_cnt != MAX_OUTST).
  - sram_rid, sram_addr, sram_reb and sram_rlast are combinational muxes of the owner's inputs.
  - Accept when sram_req & sram_ack. Then ch_ack[owner]=1 in that same cycle, and owner is pushed into the routing FIFO.
  - All other ch_ack bits are 0.
  - Accept with owner's rlast=1: rr_ptr←(owner+1) mod NUM_CH, go to IDLE.
  - Owner drops ch_req mid-burst: stay in LOCK (burst lock holds). Other channels wait.
- Full condition: outst_cnt==MAX_OUTST forces sram_req=0. The check uses the registered count only; a same-cycle pop does not unblock.
- Return path:
  - sram_rvalid with FIFO non-empty pops the head h.
  - Next cycle: ch_rvalid=1<<h and ch_rdata=sram_rdata (registered, latency 1). Otherwise ch_rvalid=0 and ch_rdata holds its last value.
- Unexpected return: sram_rvalid with FIFO empty sets err_unexp (sticky until reset). The data is dropped and ch_rvalid stays 0.
- outst_cnt: +1 on accept, −1 on valid pop, unchanged on simultaneous accept+pop. Wrap-around of FIFO pointers mod MAX_OUTST.
- Fairness: a continuously requesting channel waits at most NUM_CH−1 bursts.

Test Plan:
- Single beat: ch_req=3'b001, rid=5, addr=0x12, rlast=1, SRAM acks immediately.
  -> IDLE→LOCK in 1 cycle, then sram_req=1 with rid=5, addr=0x12 and ch_ack[0]=1.
  -> sram_rvalid with data 0xA5.. gives ch_rvalid=3'b001 and ch_rdata=0xA5.. exactly 1 cycle later.
- Round-robin: all three channels request 1-beat bursts continuously.
  -> grant order 0,1,2,0 with one IDLE cycle between grants.
  -> returns routed 001,010,100,001.
- Burst lock: ch0 issues a 3-beat burst (rlast on beat 3) while ch1 requests.
  -> ch1 gets no ack until ch0's beat-3 ack, then is granted after 1 IDLE cycle.
- Back-pressure, MAX_OUTST=4, SRAM withholds rvalid:
  -> exactly 4 accepts, then sram_req=0 and outst_cnt=4.
  -> one rvalid gives outst_cnt=3 the next cycle, and sram_req resumes.
- Simultaneous accept+pop at outst_cnt=2 -> outst_cnt stays 2, routing order preserved.
- sram_rvalid with FIFO empty -> err_unexp=1 sticky, ch_rvalid=0. Reset clears err_unexp, FSM and outst_cnt on the next posedge.
